// File: rtl/band_gain_mixer_pkg.sv
// Shared equalizer constants and the mixer FSM encoding.
package band_gain_mixer_pkg;
  localparam int DATA_W     = 24;
  localparam int GAIN_W     = 16;
  localparam int GAIN_FRAC  = 14;
  localparam int N_BANDS    = 10;
  localparam int GAIN_UNITY = 1 << GAIN_FRAC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;
endpackage

// File: rtl/band_gain_mixer_sat_round.sv
// Round half up, drop FRAC bits, then clamp to a signed OUT_W range.
module sat_round #(
  parameter int IN_W  = 44,
  parameter int OUT_W = 24,
  parameter int FRAC  = 14
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  // One spare bit so the rounding offset can never wrap the sum.
  localparam int SUM_W = IN_W + 1;
  localparam int SH_W  = SUM_W - FRAC;
  localparam logic signed [SH_W-1:0] MAX_V = SH_W'((2 ** (OUT_W-1)) - 1);
  localparam logic signed [SH_W-1:0] MIN_V = SH_W'(-(2 ** (OUT_W-1)));

  logic signed [SUM_W-1:0] sum;
  logic signed [SH_W-1:0]  shr;

  assign sum = SUM_W'(din) + SUM_W'(2 ** (FRAC-1));
  assign shr = SH_W'(sum >>> FRAC);

  always_comb begin
    dout = OUT_W'(shr);
    if (shr > MAX_V)      dout = OUT_W'(MAX_V);
    else if (shr < MIN_V) dout = OUT_W'(MIN_V);
  end
endmodule

// File: rtl/band_gain_mixer.sv
// Ten-band gain mixer: one MAC per cycle over a latched frame, rounded and saturated.
module band_gain_mixer #(
  parameter int DATA_W    = band_gain_mixer_pkg::DATA_W,
  parameter int GAIN_W    = band_gain_mixer_pkg::GAIN_W,
  parameter int GAIN_FRAC = band_gain_mixer_pkg::GAIN_FRAC,
  parameter int N_BANDS   = band_gain_mixer_pkg::N_BANDS
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_lp,
  input  logic signed [DATA_W-1:0] i_band_64_125,
  input  logic signed [DATA_W-1:0] i_band_125_250,
  input  logic signed [DATA_W-1:0] i_band_250_500,
  input  logic signed [DATA_W-1:0] i_band_500_1k,
  input  logic signed [DATA_W-1:0] i_band_1k_2k,
  input  logic signed [DATA_W-1:0] i_band_2k_4k,
  input  logic signed [DATA_W-1:0] i_band_4k_8k,
  input  logic signed [DATA_W-1:0] i_band_8k_16k,
  input  logic signed [DATA_W-1:0] i_hp,
  input  logic                     i_gain_we,
  input  logic [3:0]               i_gain_addr,
  input  logic signed [GAIN_W-1:0] i_gain_data,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_overrun
);
  import band_gain_mixer_pkg::*;

  localparam int PROD_W = DATA_W + GAIN_W;
  localparam int ACC_W  = PROD_W + 4;
  localparam logic signed [GAIN_W-1:0] UNITY = GAIN_W'(GAIN_UNITY);

  logic signed [DATA_W-1:0] band_in  [N_BANDS];
  logic signed [DATA_W-1:0] band_q   [N_BANDS];
  logic signed [GAIN_W-1:0] gain_sh  [N_BANDS];
  logic signed [GAIN_W-1:0] gain_act [N_BANDS];

  state_t                   state, state_nxt;
  logic [3:0]               idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] res;

  assign band_in[0] = i_lp;
  assign band_in[1] = i_band_64_125;
  assign band_in[2] = i_band_125_250;
  assign band_in[3] = i_band_250_500;
  assign band_in[4] = i_band_500_1k;
  assign band_in[5] = i_band_1k_2k;
  assign band_in[6] = i_band_2k_4k;
  assign band_in[7] = i_band_4k_8k;
  assign band_in[8] = i_band_8k_16k;
  assign band_in[9] = i_hp;

  assign prod   = PROD_W'(band_q[idx]) * PROD_W'(gain_act[idx]);
  assign o_busy = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (i_en) state_nxt = ST_ACC;
      ST_ACC:  if (idx == 4'(N_BANDS-1)) state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shadow bank: writes land here only; frames see it at their start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_BANDS; i++) gain_sh[i] <= UNITY;
    end else if (i_gain_we && (i_gain_addr < 4'(N_BANDS))) begin
      gain_sh[i_gain_addr] <= i_gain_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      acc       <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      for (int i = 0; i < N_BANDS; i++) begin
        gain_act[i] <= UNITY;
        band_q[i]   <= '0;
      end
    end else begin
      state   <= state_nxt;
      o_valid <= 1'b0;
      if (i_en && (state != ST_IDLE)) o_overrun <= 1'b1;
      unique case (state)
        ST_IDLE: if (i_en) begin
          band_q   <= band_in;
          gain_act <= gain_sh;
          acc      <= '0;
          idx      <= '0;
        end
        ST_ACC: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + 4'd1;
        end
        ST_OUT: begin
          o_data  <= res;
          o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  sat_round #(.IN_W(ACC_W), .OUT_W(DATA_W), .FRAC(GAIN_FRAC)) u_sat_round (
    .din  (acc),
    .dout (res)
  );
endmodule

// File: doc/band_gain_mixer.md
BAND_GAIN_MIXER -- requirements
Module: band_gain_mixer

Interface
REQ-001 Parameter DATA_W, 24, sample width (signed) of every band input and the output.
REQ-002 Parameter GAIN_W, 16, signed gain word width.
REQ-003 Parameter GAIN_FRAC, 14, gain fraction bits (Q2.14, unity = 16384).
REQ-004 Parameter N_BANDS, 10, number of band inputs.
REQ-005 i_clk  in  1  single clock; all state on rising edge.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_en  in  1  sample strobe, one cycle wide, band inputs valid in that cycle.
REQ-008 i_lp, i_band_64_125, i_band_125_250, i_band_250_500, i_band_500_1k, i_band_1k_2k, i_band_2k_4k, i_band_4k_8k, i_band_8k_16k, i_hp  in  DATA_W each  signed filter-bank outputs, band index 0..9 in that order.
REQ-009 i_gain_we  in  1  gain write strobe.
REQ-010 i_gain_addr  in  4  band index of the write.
REQ-011 i_gain_data  in  GAIN_W  signed Q2.14 gain value.
REQ-012 o_data  out  DATA_W  signed mixed, gained, saturated sample.
REQ-013 o_valid  out  1  one-cycle pulse, o_data new.
REQ-014 o_busy  out  1  high while a frame is being accumulated.
REQ-015 o_overrun  out  1  sticky flag: i_en arrived while busy.

Function
REQ-016 The block SHALL be an FSM with states IDLE, ACC, OUT.
- IDLE -> ACC on i_en: latch all 10 bands into a sample buffer, copy the shadow gain bank to the active gain bank, clear accumulator, index=0.
- ACC: one signed MAC per cycle, acc += band[index] * active_gain[index], index++; after index 9 -> OUT.
- OUT: round, saturate, register o_data, pulse o_valid, -> IDLE.
REQ-017 Latency SHALL be fixed: i_en in cycle T gives o_valid in cycle T+12; o_busy high in cycles T+1..T+11.
REQ-018 Product SHALL be DATA_W+GAIN_W = 40 bits; accumulator SHALL be 44 bits and never wrap for 10 terms.
REQ-019 Result SHALL be (acc + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC (round half up), saturated to [-8388608, 8388607].
REQ-020 o_data SHALL hold its value between o_valid pulses.
REQ-021 Gain writes SHALL go to the shadow bank in the cycle after i_gain_we and take effect at the next frame start only; a running frame is unaffected.
REQ-022 i_gain_addr >= 10 SHALL be ignored.
REQ-023 Write and frame start in the same cycle: the frame SHALL use the pre-write shadow value; the write lands in the shadow bank.
REQ-024 i_en while not IDLE SHALL be dropped and SHALL set o_overrun; o_overrun clears only on reset.
REQ-025 i_en in the OUT cycle counts as busy and is dropped.

Reset
REQ-026 On i_rst_n low, asynchronously: state=IDLE, acc=0, index=0, o_data=0, o_valid=0, o_busy=0, o_overrun=0, shadow and active gains = 16384.
REQ-027 Reset mid-frame SHALL abort the frame with no o_valid; the first i_en after release starts a clean frame.

Structure
REQ-028 DATA_W, GAIN_W, GAIN_FRAC, N_BANDS, unity-gain constant and FSM state encoding SHALL live in the shared equalizer package.
REQ-029 One sub-module sat_round (round + saturate, combinational, parameterised widths) SHALL be instantiated in the output stage.

Verification
REQ-030 Reset, all gains unity, bands = 100 each, one i_en -> o_valid 12 cycles later, o_data = 1000, o_busy high exactly 11 cycles.
REQ-031 Gain band 3 = 8192 (0.5), others 0, band 3 = 1001 -> o_data = 501 (rounded half-up); band 3 = -1001 -> -500.
REQ-032 All gains 32767, all bands 8388607 -> o_data = 8388607; all bands -8388608 -> -8388608 (saturation).
REQ-033 Write gain band 0 = 0 two cycles after i_en -> current frame still unity-gained, next frame excludes band 0.
REQ-034 Second i_en 5 cycles after first -> only one o_valid, o_overrun = 1 and stays until reset.
REQ-035 Assert i_rst_n low at cycle T+6 of a frame -> no o_valid, all outputs 0, gains back to 16384.
